// File: rtl/uart_rx.sv
// Oversampled UART receiver: majority-of-3 mid-bit sampling, optional parity,
// registered data/flag outputs with a one-cycle data_valid strobe.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, OUT} state_t;

    state_t                state_q;
    logic [5:0]            edge_cnt_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic [2:0]            smp_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic [5:0]            smp_mid;
    logic [5:0]            smp_lo;
    logic [5:0]            smp_hi;
    logic                  bit_done;
    logic                  bit_d;
    logic                  par_exp;

    always_comb begin
        smp_mid  = Prescale >> 1;
        smp_lo   = smp_mid - 6'd1;
        smp_hi   = smp_mid + 6'd1;
        bit_done = (edge_cnt_q == Prescale - 6'd1);
        bit_d    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
        par_exp  = (^shift_q) ^ par_typ_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            smp_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!RX_IN) begin
                        state_q    <= START;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        par_err_q  <= 1'b0;
                        stp_err_q  <= 1'b0;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                    end
                end
                OUT: begin
                    if (!par_err_q && !stp_err_q) begin
                        p_data_q <= shift_q;
                        valid_q  <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    if (edge_cnt_q == smp_lo) smp_q[0] <= RX_IN;
                    if (edge_cnt_q == smp_mid) smp_q[1] <= RX_IN;
                    if (edge_cnt_q == smp_hi) smp_q[2] <= RX_IN;
                    if (bit_done) begin
                        edge_cnt_q <= '0;
                        case (state_q)
                            START: state_q <= bit_d ? IDLE : DATA;
                            DATA: begin
                                // LSB-first: new bit enters at the top and walks down
                                shift_q <= (shift_q >> 1) | (DATA_WIDTH'(bit_d) << (DATA_WIDTH - 1));
                                if (bit_cnt_q == LAST_BIT) begin
                                    bit_cnt_q <= '0;
                                    state_q   <= par_en_q ? PARITY : STOP;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                end
                            end
                            PARITY: begin
                                par_err_q <= (bit_d != par_exp);
                                state_q   <= STOP;
                            end
                            STOP: begin
                                stp_err_q <= ~bit_d;
                                state_q   <= OUT;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 CLK  input  1  oversampling clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 RX_IN  input  1  serial line; idle high; LSB-first frames.
REQ-005 PAR_EN  input  1  1 = parity bit present after the data bits.
REQ-006 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Prescale  input  6  clocks per bit; legal values 8, 16, 32; held stable during a frame.
REQ-008 P_DATA  output  DATA_WIDTH  received byte, registered.
REQ-009 data_valid  output  1  one-cycle pulse: P_DATA holds a good frame.
REQ-010 par_err  output  1  registered parity error flag.
REQ-011 stp_err  output  1  registered stop-bit error flag.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
REQ-013 IDLE: RX_IN==0 sampled on a rising edge -> START next cycle, edge_cnt=0, bit_cnt=0. Otherwise stay in IDLE.
REQ-014 In every non-IDLE bit state, edge_cnt increments each cycle. At Prescale-1 it wraps to 0 and the bit ends.
REQ-015 Bit value: majority of 3 samples of RX_IN, taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-016 START end: majority 1 (glitch) -> IDLE, no flags change. Majority 0 -> DATA.
REQ-017 DATA: each bit shifts into a shift register LSB-first. bit_cnt counts 0..DATA_WIDTH-1.
REQ-018 End of data bit DATA_WIDTH-1: PAR_EN=1 -> PARITY, else -> STOP.
REQ-019 PARITY end: par_err <= (sampled bit != expected parity). Expected parity = XOR of the data bits XOR PAR_TYP. Next state STOP.
REQ-020 STOP end: stp_err <= (sampled bit == 0). Next state OUT.
REQ-021 OUT lasts one cycle. If par_err==0 and stp_err==0: P_DATA <= shift register and data_valid=1 for that cycle. Next state IDLE.
REQ-022 With PAR_EN=0, par_err is forced 0 for the frame.
REQ-023 par_err and stp_err hold their value until the next START entry, which clears both.
REQ-024 On an errored frame, data_valid stays 0 and P_DATA keeps its previous value.
REQ-025 Back-to-back frames: a low RX_IN seen in IDLE on the cycle after OUT starts the next frame. No frame is lost.
REQ-026 PAR_EN and PAR_TYP are sampled at START entry and held internally for the whole frame.
REQ-027 Illegal Prescale values give undefined data. The FSM shall still always return to IDLE.

Reset
REQ-028 RST low, at any time including mid-frame: state=IDLE, edge_cnt=0, bit_cnt=0, shift register=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0.
REQ-029 After RST rises, the first low RX_IN is treated as a new start bit. No partial frame is resumed.

Verification
REQ-030 Prescale=8, PAR_EN=0, frame 0xA5, stop=1 -> data_valid pulse for 1 cycle, P_DATA=0xA5, par_err=0, stp_err=0. Pulse occurs 81 cycles after IDLE sees the start edge (1 + 10 bits x 8).
REQ-031 Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity bit 0 -> P_DATA=0x3C, data_valid pulse. Same frame with parity bit 1 -> par_err=1, no data_valid, P_DATA unchanged.
REQ-032 Prescale=8, PAR_EN=1, PAR_TYP=1, data 0x01, parity 0, stop bit 0 -> stp_err=1, par_err=0, no data_valid.
REQ-033 Prescale=16, RX_IN low for 3 cycles then high (glitch) -> FSM returns to IDLE after the start bit, no outputs change.
REQ-034 Prescale=32, two frames 0x55 then 0xAA with no idle gap -> two data_valid pulses, P_DATA=0x55 then 0xAA.
REQ-035 Prescale=8, RST asserted during data bit 4 -> all outputs 0 immediately. A clean frame 0x0F after release -> P_DATA=0x0F, data_valid pulse.
